// File: rtl/punch_round_ctrl_if.sv
// rtl/punch_round_ctrl_if.sv - button inputs and display/verdict outputs of the round sequencer
interface punch_round_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic               hit;
    logic               abort;
    logic [1:0]         state;
    logic [2:0]         step;
    logic               busy;
    logic               result_valid;
    logic [1:0]         result;
    logic [SCORE_W-1:0] score;

    // Driven by the buttons / game logic, observes the round outputs
    modport master (
        output start, hit, abort,
        input  state, step, busy, result_valid, result, score
    );

    // The round sequencer itself
    modport slave (
        input  start, hit, abort,
        output state, step, busy, result_valid, result, score
    );
endinterface

// File: rtl/punch_round_ctrl.sv
// rtl/punch_round_ctrl.sv - boxing-game round sequencer with punch judging and saturating score
module punch_round_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int SCORE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    punch_round_ctrl_if.slave  bus
);

    localparam int                 CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [2:0]         STEP_LAST = 3'd4;

    localparam logic [1:0] RES_HIT  = 2'b01;
    localparam logic [1:0] RES_MISS = 2'b10;
    localparam logic [1:0] RES_FOUL = 2'b11;

    // Encoding doubles as the display mode driven on bus.state
    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_COUNTDOWN = 2'b01,
        S_CHARGE    = 2'b10,
        S_SWEEP     = 2'b11
    } state_t;

    state_t             r_state;
    logic [2:0]         r_step;
    logic               r_busy;
    logic               r_result_valid;
    logic [1:0]         r_result;
    logic [SCORE_W-1:0] r_score;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_start_d;
    logic               r_hit_d;

    logic w_start_rise;
    logic w_hit_rise;
    logic w_tick;
    logic w_last_step;

    // Only rising edges act, so a held button never triggers twice
    assign w_start_rise = bus.start & ~r_start_d;
    assign w_hit_rise   = bus.hit & ~r_hit_d;
    assign w_tick       = (r_cnt == CNT_MAX);
    assign w_last_step  = (r_step == STEP_LAST);

    assign bus.state        = r_state;
    assign bus.step         = r_step;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_result_valid;
    assign bus.result       = r_result;
    assign bus.score        = r_score;

    // Round FSM: abort beats hit_rise beats tick; every state change restarts the prescaler
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_step         <= 3'd0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= 2'b00;
            r_score        <= '0;
            r_cnt          <= '0;
            r_start_d      <= 1'b0;
            r_hit_d        <= 1'b0;
        end else begin
            r_start_d      <= bus.start;
            r_hit_d        <= bus.hit;
            r_result_valid <= 1'b0;

            if (bus.abort) begin
                r_state <= S_IDLE;
                r_step  <= 3'd0;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_step <= 3'd0;
                        r_cnt  <= '0;
                        if (w_start_rise) begin
                            r_state <= S_COUNTDOWN;
                            r_busy  <= 1'b1;
                        end
                    end

                    S_COUNTDOWN: begin
                        if (w_tick) begin
                            r_cnt <= '0;
                            if (w_last_step) begin
                                r_state <= S_CHARGE;
                                r_step  <= 3'd0;
                            end else begin
                                r_step <= r_step + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    S_CHARGE: begin
                        if (w_hit_rise) begin
                            // Punching before the sweep is a foul regardless of step
                            r_state        <= S_IDLE;
                            r_step         <= 3'd0;
                            r_busy         <= 1'b0;
                            r_cnt          <= '0;
                            r_result       <= RES_FOUL;
                            r_result_valid <= 1'b1;
                        end else if (w_tick) begin
                            r_cnt <= '0;
                            if (w_last_step) begin
                                r_state <= S_SWEEP;
                                r_step  <= 3'd0;
                            end else begin
                                r_step <= r_step + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    S_SWEEP: begin
                        if (w_hit_rise) begin
                            // Only the last sweep step is the scoring window
                            r_state        <= S_IDLE;
                            r_step         <= 3'd0;
                            r_busy         <= 1'b0;
                            r_cnt          <= '0;
                            r_result_valid <= 1'b1;
                            if (w_last_step) begin
                                r_result <= RES_HIT;
                                if (r_score != SCORE_MAX) begin
                                    r_score <= r_score + SCORE_W'(1);
                                end
                            end else begin
                                r_result <= RES_MISS;
                            end
                        end else if (w_tick) begin
                            r_cnt <= '0;
                            if (w_last_step) begin
                                // Window closed without a punch
                                r_state        <= S_IDLE;
                                r_step         <= 3'd0;
                                r_busy         <= 1'b0;
                                r_result       <= RES_MISS;
                                r_result_valid <= 1'b1;
                            end else begin
                                r_step <= r_step + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_step  <= 3'd0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_punch_round_ctrl.sv
// tb/tb_punch_round_ctrl.sv - self-checking bench for punch_round_ctrl
module tb_punch_round_ctrl;

    localparam int TD = 4;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    punch_round_ctrl_if #(.SCORE_W(SW)) bus();

    punch_round_ctrl #(.TICK_DIV(TD), .SCORE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: a round is "active" for t = 0 .. 15*TD-1 cycles since entry
    bit         m_active;
    int         m_t;
    logic [1:0] m_result;
    int         m_score;
    bit         m_valid;
    bit         m_pstart;
    bit         m_phit;

    function automatic void model_reset();
        m_active = 0; m_t = 0; m_result = 2'b00; m_score = 0;
        m_valid = 0; m_pstart = 0; m_phit = 0;
    endfunction

    function automatic void model_edge(input bit s, input bit h, input bit a);
        bit sr, hr, tk;
        int ph, st;
        sr = s && !m_pstart;
        hr = h && !m_phit;
        m_pstart = s;
        m_phit = h;
        m_valid = 0;
        if (a) begin
            m_active = 0;
        end else if (m_active) begin
            ph = m_t / (5 * TD);
            st = (m_t / TD) % 5;
            tk = (m_t % TD) == TD - 1;
            if (hr && ph == 1) begin
                m_result = 2'b11; m_valid = 1; m_active = 0;
            end else if (hr && ph == 2) begin
                if (st == 4) begin
                    m_result = 2'b01;
                    if (m_score < SMAX) m_score++;
                end else begin
                    m_result = 2'b10;
                end
                m_valid = 1; m_active = 0;
            end else if (ph == 2 && st == 4 && tk) begin
                m_result = 2'b10; m_valid = 1; m_active = 0;
            end else begin
                m_t++;
            end
        end else if (sr) begin
            m_active = 1; m_t = 0;
        end
    endfunction

    function automatic logic [12:0] model_vec();
        logic [1:0] es;
        logic [2:0] ep;
        es = m_active ? 2'(m_t / (5 * TD) + 1) : 2'b00;
        ep = m_active ? 3'((m_t / TD) % 5) : 3'd0;
        return {es, ep, m_active, m_valid, m_result, 4'(m_score)};
    endfunction

    // One clock: inputs seen at the edge feed the model, then settle 1ns past the edge
    task automatic cyc();
        bit s, h, a;
        s = bus.start; h = bus.hit; a = bus.abort;
        @(posedge clk);
        if (rst) model_edge(s, h, a);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if ({bus.state, bus.step, bus.busy, bus.result_valid, bus.result, bus.score} !== 13'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {bus.state, bus.step, bus.busy, bus.result_valid, bus.result, bus.score}); end
        rst = 1'b1;
        run(4);
        n_checks++; if (bus.state !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_hold: state %0d busy %0d want 0 0", bus.state, bus.busy); end
    endtask

    task automatic test_timeout();
        press_start();
        n_checks++; if (bus.state !== 2'b01 || bus.busy !== 1'b1 || bus.step !== 3'd0) begin n_fail++; $display("FAIL timeout_entry: state %0d busy %0d step %0d want 1 1 0", bus.state, bus.busy, bus.step); end
        for (int k = 1; k <= 60; k++) begin
            logic [1:0] es;
            logic [2:0] ep;
            cyc();
            es = (k < 20) ? 2'b01 : (k < 40) ? 2'b10 : (k < 60) ? 2'b11 : 2'b00;
            ep = (k < 60) ? 3'((k / 4) % 5) : 3'd0;
            n_checks++; if (bus.state !== es || bus.step !== ep) begin n_fail++; $display("FAIL timeout_seq k=%0d: state %0d step %0d want %0d %0d", k, bus.state, bus.step, es, ep); end
            n_checks++; if (bus.result_valid !== (k == 60)) begin n_fail++; $display("FAIL timeout_valid k=%0d: got %0d want %0d", k, bus.result_valid, (k == 60)); end
        end
        n_checks++; if (bus.result !== 2'b10 || bus.score !== 4'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_verdict: result %0d score %0d busy %0d want 2 0 0", bus.result, bus.score, bus.busy); end
        cyc();
        n_checks++; if (bus.result_valid !== 1'b0 || bus.result !== 2'b10) begin n_fail++; $display("FAIL timeout_after: valid %0d result %0d want 0 2", bus.result_valid, bus.result); end
    endtask

    task automatic test_hit_window();
        int t_hit[2] = '{57, 59};
        for (int v = 0; v < 2; v++) begin
            press_start();
            run(t_hit[v]);
            bus.hit = 1'b1;
            cyc();
            bus.hit = 1'b0;
            n_checks++; if (bus.state !== 2'b00 || bus.result !== 2'b01 || bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL hit_window t=%0d: state %0d result %0d valid %0d want 0 1 1", t_hit[v], bus.state, bus.result, bus.result_valid); end
            n_checks++; if (bus.score !== 4'(v + 1)) begin n_fail++; $display("FAIL hit_score t=%0d: got %0d want %0d", t_hit[v], bus.score, v + 1); end
            cyc();
            n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_len: got %0d want 0", bus.result_valid); end
        end
    endtask

    task automatic test_foul();
        press_start();
        run(29);
        bus.hit = 1'b1;
        cyc();
        bus.hit = 1'b0;
        n_checks++; if (bus.state !== 2'b00 || bus.result !== 2'b11 || bus.result_valid !== 1'b1 || bus.score !== 4'd2) begin n_fail++; $display("FAIL foul_charge: state %0d result %0d valid %0d score %0d want 0 3 1 2", bus.state, bus.result, bus.result_valid, bus.score); end
        press_start();
        run(13);
        bus.hit = 1'b1;
        cyc();
        n_checks++; if (bus.state !== 2'b01 || bus.step !== 3'd3 || bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL countdown_hit_ignored: state %0d step %0d valid %0d want 1 3 0", bus.state, bus.step, bus.result_valid); end
        bus.hit = 1'b0;
        run(46);
        n_checks++; if (bus.state !== 2'b00 || bus.result !== 2'b10 || bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL countdown_hit_round_end: state %0d result %0d valid %0d want 0 2 1", bus.state, bus.result, bus.result_valid); end
    endtask

    task automatic test_held();
        press_start();
        run(2);
        bus.hit = 1'b1;
        run(57);
        n_checks++; if (bus.state !== 2'b11 || bus.step !== 3'd4) begin n_fail++; $display("FAIL held_still_sweep: state %0d step %0d want 3 4", bus.state, bus.step); end
        cyc();
        n_checks++; if (bus.state !== 2'b00 || bus.result !== 2'b10 || bus.result_valid !== 1'b1 || bus.score !== 4'd2) begin n_fail++; $display("FAIL held_timeout: state %0d result %0d valid %0d score %0d want 0 2 1 2", bus.state, bus.result, bus.result_valid, bus.score); end
        bus.hit = 1'b0;
        cyc();
    endtask

    task automatic test_abort();
        press_start();
        run(45);
        n_checks++; if (bus.state !== 2'b11 || bus.step !== 3'd1) begin n_fail++; $display("FAIL abort_pre: state %0d step %0d want 3 1", bus.state, bus.step); end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        n_checks++; if (bus.state !== 2'b00 || bus.result_valid !== 1'b0 || bus.result !== 2'b10 || bus.score !== 4'd2 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort: state %0d valid %0d result %0d score %0d busy %0d want 0 0 2 2 0", bus.state, bus.result_valid, bus.result, bus.score, bus.busy); end
        cyc();
        n_checks++; if (bus.result_valid !== 1'b0 || bus.state !== 2'b00) begin n_fail++; $display("FAIL abort_after: valid %0d state %0d want 0 0", bus.result_valid, bus.state); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int r = 1; r <= 16; r++) begin
            int want;
            want = (r < SMAX) ? r : SMAX;
            press_start();
            run(58);
            bus.hit = 1'b1;
            cyc();
            bus.hit = 1'b0;
            n_checks++; if (bus.score !== 4'(want) || bus.result !== 2'b01) begin n_fail++; $display("FAIL saturation round %0d: score %0d result %0d want %0d 1", r, bus.score, bus.result, want); end
        end
    endtask

    task automatic test_reset_midround();
        press_start();
        run(45);
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.state, bus.step, bus.busy, bus.result_valid, bus.result, bus.score} !== 13'd0) begin n_fail++; $display("FAIL reset_midround: got %h want 0", {bus.state, bus.step, bus.busy, bus.result_valid, bus.result, bus.score}); end
        model_reset();
        #3;
        rst = 1'b1;
        run(5);
        n_checks++; if (bus.state !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: state %0d busy %0d want 0 0", bus.state, bus.busy); end
        press_start();
        n_checks++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL reset_restart: state %0d want 1", bus.state); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            logic [12:0] got, want;
            bus.start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) bus.hit = ~bus.hit;
            bus.abort = ($urandom_range(0, 199) == 0);
            cyc();
            got  = {bus.state, bus.step, bus.busy, bus.result_valid, bus.result, bus.score};
            want = model_vec();
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL random cycle %0d: got %h want %h", i, got, want); end
        end
        bus.start = 1'b0; bus.hit = 1'b0; bus.abort = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.hit   = 1'b0;
        bus.abort = 1'b0;
        model_reset();
        test_reset();
        test_timeout();
        test_hit_window();
        test_foul();
        test_held();
        test_abort();
        test_saturation();
        test_reset_midround();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
